// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset level, bus widths
// and fetch FSM state encodings.
package if_fetch_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_RECV  = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_fetch_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage: combinational
// read, synchronous write; only valid bits are cleared by reset.
module icache_array
  import if_fetch_pkg::*;
#(
  parameter int unsigned LINES = 128,
  parameter int unsigned TAG_W = 23,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [InstBus-1:0] o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [InstBus-1:0] i_wr_data
);

  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [InstBus-1:0] r_data [LINES];
  logic [LINES-1:0]   r_valid;

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in == RstEnable) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: optional direct-mapped I-cache (IF_ICACHE_EN) in
// front of a byte-wide memory port; misses are filled with 4 little-endian byte reads.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 128,
  parameter int unsigned ADDR_W       = InstAddrBus
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic [InstBus-1:0] inst_out,
  output logic [ADDR_W-1:0]  inst_pc_out,
  output logic               inst_valid_out,
  output logic               stallreq_out,
  output logic               mem_req_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  input  logic               mem_grant_in,
  input  logic [7:0]         mem_data_in,
  input  logic               mem_data_valid_in
);

  if_state_e          r_state;
  logic [1:0]         r_cnt;
  logic [ADDR_W-1:0]  r_pc;
  logic [23:0]        r_buf;

  logic [1:0]         w_cnt_nxt;
  logic [InstBus-1:0] w_word;
  logic [ADDR_W-1:0]  w_fetch_addr;
  logic               w_hit;
  logic [InstBus-1:0] w_rd_data;

  assign w_cnt_nxt    = r_cnt + 2'd1;
  assign w_word       = {mem_data_in, r_buf};
  assign w_fetch_addr = {pc_in[ADDR_W-1:2], 2'b00};

`ifdef IF_ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  logic [TAG_W-1:0] w_rd_tag;
  logic             w_rd_valid;
  logic             w_fill;

  // Line is written on byte 3 in both RECV and DRAIN, so flushed fills still cache.
  assign w_fill = rdy_in && mem_data_valid_in && (r_cnt == 2'd3) &&
                  ((r_state == IF_RECV) || (r_state == IF_DRAIN));
  assign w_hit  = w_rd_valid && (w_rd_tag == pc_in[ADDR_W-1:IDX_W+2]);

  icache_array #(
    .LINES (ICACHE_LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_icache (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_rd_idx   (pc_in[IDX_W+1:2]),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_fill),
    .i_wr_idx   (r_pc[IDX_W+1:2]),
    .i_wr_tag   (r_pc[ADDR_W-1:IDX_W+2]),
    .i_wr_data  (w_word)
  );
`else
  assign w_hit     = 1'b0;
  assign w_rd_data = ZeroWord;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in == RstEnable) begin
      r_state        <= IF_IDLE;
      r_cnt          <= '0;
      r_pc           <= '0;
      r_buf          <= '0;
      inst_out       <= ZeroWord;
      inst_pc_out    <= '0;
      inst_valid_out <= 1'b0;
      stallreq_out   <= 1'b0;
      mem_req_out    <= 1'b0;
      mem_addr_out   <= '0;
    end else if (rdy_in) begin
      unique case (r_state)
        IF_IDLE: begin
          if (flush_in) begin
            inst_valid_out <= 1'b0;
            stallreq_out   <= 1'b0;
            mem_req_out    <= 1'b0;
          end else if (!stall_in) begin
            if (w_hit) begin
              inst_out       <= w_rd_data;
              inst_pc_out    <= pc_in;
              inst_valid_out <= 1'b1;
            end else begin
              r_pc           <= pc_in;
              mem_req_out    <= 1'b1;
              mem_addr_out   <= w_fetch_addr;
              stallreq_out   <= 1'b1;
              inst_valid_out <= 1'b0;
              r_state        <= IF_REQ;
            end
          end
        end
        IF_REQ: begin
          if (mem_grant_in) begin
            mem_req_out <= 1'b0;
            r_cnt       <= '0;
            r_state     <= flush_in ? IF_DRAIN : IF_RECV;
          end else if (flush_in) begin
            mem_req_out  <= 1'b0;
            stallreq_out <= 1'b0;
            r_state      <= IF_IDLE;
          end
        end
        IF_RECV, IF_DRAIN: begin
          if (mem_data_valid_in) begin
            case (r_cnt)
              2'd0:    r_buf[7:0]   <= mem_data_in;
              2'd1:    r_buf[15:8]  <= mem_data_in;
              2'd2:    r_buf[23:16] <= mem_data_in;
              default: ;
            endcase
            r_cnt <= w_cnt_nxt;
            if (r_cnt == 2'd3) begin
              r_state      <= IF_IDLE;
              stallreq_out <= 1'b0;
              if ((r_state == IF_RECV) && !flush_in) begin
                inst_out       <= w_word;
                inst_pc_out    <= r_pc;
                inst_valid_out <= 1'b1;
              end
            end else begin
              mem_addr_out <= {r_pc[ADDR_W-1:2], w_cnt_nxt};
              if (flush_in) r_state <= IF_DRAIN;
            end
          end else if (flush_in) begin
            r_state <= IF_DRAIN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: scripted fetches against a byte memory
// model with a scoreboard of expected {pc, instruction} results.
module tb_if_fetch;

`ifdef IF_ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] pc_in = '0;
  logic        stall_in = 1'b1;
  logic        flush_in = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_valid_out;
  logic        stallreq_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_grant_in = 1'b0;
  logic [7:0]  mem_data_in = '0;
  logic        mem_data_valid_in = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_in = ~clk_in;

  if_fetch #(
    .ICACHE_LINES (128),
    .ADDR_W       (32)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .pc_in             (pc_in),
    .stall_in          (stall_in),
    .flush_in          (flush_in),
    .inst_out          (inst_out),
    .inst_pc_out       (inst_pc_out),
    .inst_valid_out    (inst_valid_out),
    .stallreq_out      (stallreq_out),
    .mem_req_out       (mem_req_out),
    .mem_addr_out      (mem_addr_out),
    .mem_grant_in      (mem_grant_in),
    .mem_data_in       (mem_data_in),
    .mem_data_valid_in (mem_data_valid_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] base);
    case (base)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0200: return 32'hDEAD_BEEF;
      32'h0000_0040: return 32'h1234_5678;
      32'h0000_0080: return 32'hCAFE_F00D;
      32'h0000_00C0: return 32'h0BAD_C0DE;
      default:       return 32'hA5A5_A5A5;
    endcase
  endfunction

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("inst", inst_out, e.inst);
      check("inst_pc", inst_pc_out, e.pc);
      check("inst_valid", {31'd0, inst_valid_out}, 32'd1);
    end
  endtask

  // Leaves stall_in=1 afterwards so the presented instruction is held.
  task automatic do_fetch(input logic [31:0] pc, input bit want_hit,
                          input int flush_at, input int rdy_at);
    logic [31:0] base;
    logic [31:0] word;
    bit          hit;
    base = {pc[31:2], 2'b00};
    word = word_at(base);
    hit  = want_hit && CACHE;
    pc_in    = pc;
    stall_in = 1'b0;
    if (flush_at < 0) sb_q.push_back('{pc, word});
    step();
    if (hit) begin
      check("hit_no_req", {31'd0, mem_req_out}, 32'd0);
      check("hit_no_stallreq", {31'd0, stallreq_out}, 32'd0);
      sb_compare();
    end else begin
      check("miss_valid", {31'd0, inst_valid_out}, 32'd0);
      check("miss_stallreq", {31'd0, stallreq_out}, 32'd1);
      check("miss_req", {31'd0, mem_req_out}, 32'd1);
      check("miss_addr", mem_addr_out, base);
      step();
      check("req_hold", {31'd0, mem_req_out}, 32'd1);
      mem_grant_in = 1'b1;
      step();
      mem_grant_in = 1'b0;
      check("req_drop", {31'd0, mem_req_out}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        check("byte_addr", mem_addr_out, base + 32'(k));
        if (k == rdy_at) begin
          rdy_in            = 1'b0;
          mem_data_valid_in = 1'b1;
          mem_data_in       = 8'hFF;
          repeat (5) step();
          check("frz_addr", mem_addr_out, base + 32'(k));
          check("frz_stallreq", {31'd0, stallreq_out}, 32'd1);
          check("frz_valid", {31'd0, inst_valid_out}, 32'd0);
          rdy_in            = 1'b1;
          mem_data_valid_in = 1'b0;
        end
        if (k == flush_at) begin
          flush_in = 1'b1;
          step();
          flush_in = 1'b0;
          check("drain_stallreq", {31'd0, stallreq_out}, 32'd1);
        end
        mem_data_in       = word[8*k +: 8];
        mem_data_valid_in = 1'b1;
        step();
        mem_data_valid_in = 1'b0;
        check("recv_stallreq", {31'd0, stallreq_out}, (k < 3) ? 32'd1 : 32'd0);
        if (k < 3) check("recv_valid", {31'd0, inst_valid_out}, 32'd0);
      end
      if (flush_at >= 0) check("flushed_valid", {31'd0, inst_valid_out}, 32'd0);
      else               sb_compare();
    end
    stall_in = 1'b1;
  endtask

  initial begin
    repeat (3) step();
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", inst_pc_out, 32'd0);
    check("rst_valid", {31'd0, inst_valid_out}, 32'd0);
    check("rst_stallreq", {31'd0, stallreq_out}, 32'd0);
    check("rst_req", {31'd0, mem_req_out}, 32'd0);
    check("rst_addr", mem_addr_out, 32'd0);
    rst_in = 1'b0;
    step();

    do_fetch(32'h0, 1'b0, -1, -1);
    do_fetch(32'h0, 1'b1, -1, -1);

    pc_in = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst", inst_out, 32'h0000_0013);
      check("stall_pc", inst_pc_out, 32'h0);
      check("stall_valid", {31'd0, inst_valid_out}, 32'd1);
      check("stall_req", {31'd0, mem_req_out}, 32'd0);
    end

    do_fetch(32'h200, 1'b0, -1, -1);
    do_fetch(32'h0, 1'b0, -1, -1);
    do_fetch(32'h40, 1'b0, 2, -1);
    do_fetch(32'h40, 1'b1, -1, -1);
    do_fetch(32'h80, 1'b0, -1, 2);
    do_fetch(32'h81, 1'b1, -1, -1);

    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("flush_over_stall", {31'd0, inst_valid_out}, 32'd0);

    pc_in    = 32'h100;
    stall_in = 1'b0;
    step();
    check("req_flush_pre", {31'd0, mem_req_out}, 32'd1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    stall_in = 1'b1;
    check("req_flush_req", {31'd0, mem_req_out}, 32'd0);
    check("req_flush_stallreq", {31'd0, stallreq_out}, 32'd0);
    check("req_flush_valid", {31'd0, inst_valid_out}, 32'd0);

    pc_in    = 32'hC0;
    stall_in = 1'b0;
    step();
    mem_grant_in = 1'b1;
    step();
    mem_grant_in      = 1'b0;
    mem_data_in       = 8'hDE;
    mem_data_valid_in = 1'b1;
    step();
    mem_data_valid_in = 1'b0;
    stall_in = 1'b1;
    rst_in   = 1'b1;
    step();
    rst_in = 1'b0;
    check("midrst_stallreq", {31'd0, stallreq_out}, 32'd0);
    check("midrst_req", {31'd0, mem_req_out}, 32'd0);
    check("midrst_addr", mem_addr_out, 32'd0);
    check("midrst_valid", {31'd0, inst_valid_out}, 32'd0);
    step();
    do_fetch(32'h0, 1'b0, -1, -1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register: takes the current fetch PC and returns the 32-bit instruction for the IF/ID latch.
- Direct-mapped instruction cache (optional) in front of a byte-wide memory-controller port; a miss is filled with 4 sequential byte reads, assembled little-endian.
- Raises a stall request while a miss is outstanding.
- Honours the branch-redirect flush from the PC stage.

Parameters:
- ICACHE_LINES, 128, number of one-word lines; power of 2. IDX_W = log2(ICACHE_LINES); TAG_W = 32 - 2 - IDX_W.
- ADDR_W, 32, fetch address width.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, reset; synchronous, active-high.
- rdy_in, input, 1, global ready; when 0, all state and outputs freeze.
- pc_in, input, ADDR_W, fetch PC from the PC register.
- stall_in, input, 1, downstream stall (stall[1]); holds the presented instruction.
- flush_in, input, 1, branch redirect/mispredict; discards the in-flight fetch.
- inst_out, output, 32, fetched instruction.
- inst_pc_out, output, ADDR_W, PC of inst_out.
- inst_valid_out, output, 1, inst_out/inst_pc_out valid.
- stallreq_out, output, 1, stall request to the controller (drives stall[0]).
- mem_req_out, output, 1, byte-read request to the memory controller.
- mem_addr_out, output, ADDR_W, byte address of the request.
- mem_grant_in, input, 1, controller accepted the request this cycle.
- mem_data_in, input, 8, returned byte.
- mem_data_valid_in, input, 1, mem_data_in valid.

Behaviour:
- Reset (rst_in=1 at posedge): state IDLE, byte counter 0, all line valid bits 0; inst_out=0, inst_pc_out=0, inst_valid_out=0, stallreq_out=0, mem_req_out=0, mem_addr_out=0. Reset mid-miss abandons the transaction with no drain.
- rdy_in=0: no register changes at all; reset still has priority.
- Address split: pc_in[1:0] ignored; fetch address = {pc_in[31:2], 2'b00}; index = pc_in[IDX_W+1:2]; tag = pc_in[31:IDX_W+2].
- FSM states: IDLE, REQ, RECV, DRAIN.
- IDLE, hit (valid && tag match, stall_in=0, flush_in=0): next cycle inst_out = line data, inst_pc_out = pc_in, inst_valid_out=1. Hit latency is 1 cycle.
- IDLE, miss: go to REQ; stallreq_out=1 from the next cycle; mem_req_out=1, mem_addr_out = fetch address.
- REQ: hold mem_req_out/mem_addr_out until mem_grant_in=1, then go to RECV with counter=0.
- RECV: each mem_data_valid_in writes mem_data_in into byte[counter] (byte0 = bits 7:0) and increments the counter.
  - After byte 3: write the line (data, tag, valid=1), present the instruction with inst_valid_out=1 on the next cycle, clear stallreq_out that same cycle, return to IDLE.
  - mem_addr_out tracks fetch address + counter per byte for the controller's sequential reads.
- flush_in=1:
  - IDLE/REQ without grant: drop the request, inst_valid_out=0 next cycle, stay/return to IDLE, stallreq_out=0.
  - RECV: go to DRAIN; keep receiving the remaining bytes, fill the cache line, but never assert inst_valid_out for them; return to IDLE after byte 3. stallreq_out stays 1 through DRAIN.
  - flush_in and byte-3 arrival in the same cycle: line is filled, output suppressed.
- stall_in=1 with inst_valid_out=1: inst_out, inst_pc_out and inst_valid_out hold; no new lookup. flush_in overrides stall_in and clears inst_valid_out.
- No hit lookup occurs while in REQ/RECV/DRAIN; only one outstanding miss exists at a time.

Optional Feature:
- IF_ICACHE_EN defined: tag/data/valid arrays present; hits complete in 1 cycle.
- Not defined: no arrays; every fetch takes the miss path (REQ/RECV); line writes are removed; all other behaviour is identical.

Decomposition:
- Shared defines: RstEnable, ZeroWord, InstAddrBus, InstBus, state encodings IF_IDLE/IF_REQ/IF_RECV/IF_DRAIN.
- One sub-module, icache_array: the tag/data/valid storage with a combinational read and a synchronous write port; it is instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset, then pc_in=0x0; memory returns bytes 0x13,0x00,0x00,0x00 -> mem_addr_out 0x0..0x3 in sequence, stallreq_out high until inst_out=0x00000013, inst_pc_out=0x0, inst_valid_out=1.
- Fetch 0x0 again after the fill -> inst_valid_out=1 one cycle later with 0x00000013 and no mem_req_out (IF_ICACHE_EN only).
- Conflict: fetch 0x200 with ICACHE_LINES=128 (same index as 0x0) -> miss, refill; a later fetch of 0x0 misses again.
- flush_in asserted after 2 bytes of the 0x40 miss -> remaining 2 bytes consumed, inst_valid_out never set for 0x40; the next fetch of 0x40 hits.
- stall_in=1 while inst_valid_out=1 with 0x00000013 -> outputs held constant for 3 stall cycles.
- rdy_in=0 for 5 cycles mid-RECV -> counter, outputs and state unchanged; the fetch completes correctly after rdy_in returns to 1.
